// File: rtl/masked_and_pipe_pkg.sv
// Shared types and index helpers for the DOM masked AND/XOR pipeline.
// Pair (i,j) maps to a randomness word; ordered pair (i,j) maps to a cross-term lane.
package masked_pkg;

    localparam int unsigned MAX_SHARES = 4;

    typedef enum logic {
        OP_AND = 1'b0,
        OP_XOR = 1'b1
    } op_e;

    function automatic int unsigned n_rnd(input int unsigned shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Lexicographic index of unordered pair (i<j): (0,1),(0,2),..,(1,2),..
    function automatic int unsigned rnd_idx(input int unsigned i, input int unsigned j,
                                            input int unsigned shares);
        int unsigned idx;
        idx = 0;
        for (int unsigned k = 0; k < i; k++) begin
            idx += shares - 1 - k;
        end
        return idx + (j - i - 1);
    endfunction

    // Dense index of ordered pair (i,j), i != j, skipping the diagonal.
    function automatic int unsigned lane_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned shares);
        return i * (shares - 1) + ((j < i) ? j : (j - 1));
    endfunction

endpackage

// File: rtl/masked_and_pipe_cross.sv
// One registered DOM cross-domain lane: c_ij = (a_i & b_j) ^ z, or 0 for XOR.
// Loads only when enabled so stalled lanes never toggle.
module dom_cross_term
    import masked_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             en,
    input  logic             op_xor,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_j,
    input  logic [WIDTH-1:0] z_ij,
    output logic [WIDTH-1:0] c_q
);

    logic [WIDTH-1:0] c_d;

    always_comb begin
        c_d = c_q;
        if (en) begin
            c_d = (op_e'(op_xor) == OP_XOR) ? '0 : ((a_i & b_j) ^ z_ij);
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/masked_and_pipe.sv
// Two-stage DOM-indep masked AND/XOR over SHARES shares of WIDTH bits.
// Stage 1 registers every inner and blinded cross term separately; stage 2 compresses.
module masked_and_pipe
    import masked_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SHARES = 2,
    parameter int unsigned NRND   = n_rnd(SHARES)
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op_xor,
    input  logic [SHARES*WIDTH-1:0]  a_sh,
    input  logic [SHARES*WIDTH-1:0]  b_sh,
    input  logic [NRND*WIDTH-1:0]    rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SHARES*WIDTH-1:0]  q_sh
);

    localparam int unsigned NLANE = SHARES * (SHARES - 1);

    if (SHARES < 2 || SHARES > MAX_SHARES) begin : g_bad_shares
        $fatal(1, "masked_and_pipe: SHARES out of range");
    end

    logic v1_q, v1_d, v2_q, v2_d;
    logic ready1, fire1, fire2;
    logic [SHARES-1:0][WIDTH-1:0] p_q, p_d;
    logic [SHARES-1:0][WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0]             c_q [NLANE];

    assign ready1    = !v2_q | out_ready;
    assign in_ready  = !v1_q | ready1;
    assign fire1     = in_valid & in_ready;
    assign fire2     = v1_q & ready1;
    assign out_valid = v2_q;
    assign q_sh      = q_q;

    always_comb begin
        v1_d = fire1 | (v1_q & !ready1);
        v2_d = fire2 | (v2_q & !out_ready);
    end

    always_comb begin
        p_d = p_q;
        if (fire1) begin
            for (int unsigned i = 0; i < SHARES; i++) begin
                p_d[i] = (op_e'(op_xor) == OP_XOR)
                       ? (a_sh[i*WIDTH +: WIDTH] ^ b_sh[i*WIDTH +: WIDTH])
                       : (a_sh[i*WIDTH +: WIDTH] & b_sh[i*WIDTH +: WIDTH]);
            end
        end
    end

    // Each domain folds only its own registered terms, so no unblinded mix ever settles.
    for (genvar i = 0; i < SHARES; i++) begin : g_row
        for (genvar j = 0; j < SHARES; j++) begin : g_col
            if (i != j) begin : g_lane
                localparam int unsigned LO = (i < j) ? i : j;
                localparam int unsigned HI = (i < j) ? j : i;
                localparam int unsigned RI = rnd_idx(LO, HI, SHARES);
                localparam int unsigned LI = lane_idx(i, j, SHARES);

                dom_cross_term #(.WIDTH(WIDTH)) u_term (
                    .g_clk   (g_clk),
                    .g_resetn(g_resetn),
                    .en      (fire1),
                    .op_xor  (op_xor),
                    .a_i     (a_sh[i*WIDTH +: WIDTH]),
                    .b_j     (b_sh[j*WIDTH +: WIDTH]),
                    .z_ij    (rnd[RI*WIDTH +: WIDTH]),
                    .c_q     (c_q[LI])
                );
            end
        end
    end

    always_comb begin
        q_d = q_q;
        if (fire2) begin
            for (int unsigned i = 0; i < SHARES; i++) begin
                q_d[i] = p_q[i];
                for (int unsigned j = 0; j < SHARES; j++) begin
                    if (j != i) begin
                        q_d[i] = q_d[i] ^ c_q[lane_idx(i, j, SHARES)];
                    end
                end
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            p_q  <= '0;
            q_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            p_q  <= p_d;
            q_q  <= q_d;
        end
    end

endmodule

// File: tb/tb_masked_and_pipe.sv
// Directed bench for masked_and_pipe: 2-share/8-bit vectors plus a 3-share/32-bit random run.
module tb_masked_and_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        iv2, ir2, op2, ov2, or2;
    logic [15:0] a2, b2, q2;
    logic [7:0]  r2;

    logic        iv3, ir3, op3, ov3, or3;
    logic [95:0] a3, b3, r3, q3;

    int n_chk  = 0;
    int n_fail = 0;

    masked_and_pipe #(.WIDTH(8), .SHARES(2)) dut2 (
        .g_clk(clk), .g_resetn(rstn), .in_valid(iv2), .in_ready(ir2), .op_xor(op2),
        .a_sh(a2), .b_sh(b2), .rnd(r2), .out_valid(ov2), .out_ready(or2), .q_sh(q2)
    );

    masked_and_pipe #(.WIDTH(32), .SHARES(3)) dut3 (
        .g_clk(clk), .g_resetn(rstn), .in_valid(iv3), .in_ready(ir3), .op_xor(op3),
        .a_sh(a3), .b_sh(b3), .rnd(r3), .out_valid(ov3), .out_ready(or3), .q_sh(q3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected 2-share DOM output written straight from the gadget equations.
    function automatic logic [15:0] ref2(input logic [15:0] a, input logic [15:0] b,
                                         input logic [7:0] r, input logic op);
        logic [7:0] q0, q1;
        if (op) begin
            q0 = a[7:0] ^ b[7:0];
            q1 = a[15:8] ^ b[15:8];
        end else begin
            q0 = (a[7:0] & b[7:0]) ^ ((a[7:0] & b[15:8]) ^ r);
            q1 = (a[15:8] & b[15:8]) ^ ((a[15:8] & b[7:0]) ^ r);
        end
        return {q1, q0};
    endfunction

    function automatic logic [31:0] fold3(input logic [95:0] v);
        return v[31:0] ^ v[63:32] ^ v[95:64];
    endfunction

    logic [15:0] ta [4] = '{16'h1234, 16'hF00F, 16'hA5C3, 16'h0FF0};
    logic [15:0] tb [4] = '{16'h5678, 16'h3C3C, 16'hFFFF, 16'h8001};
    logic [7:0]  tr [4] = '{8'h11, 8'hE2, 8'h00, 8'h5B};

    logic [31:0] eq [$];
    logic [95:0] qa, qb, rb;
    logic [31:0] ua, ub;

    initial begin
        rstn = 1'b0;
        iv2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0; r2 = '0; or2 = 1'b1;
        iv3 = 1'b0; op3 = 1'b0; a3 = '0; b3 = '0; r3 = '0; or3 = 1'b1;
        step();
        step();
        chk("rst_ov2", 128'(ov2), 128'(1'b0));
        chk("rst_q2", 128'(q2), 128'(16'h0));
        chk("rst_ir2", 128'(ir2), 128'(1'b1));
        chk("rst_ov3", 128'(ov3), 128'(1'b0));
        chk("rst_q3", 128'(q3), 128'(96'h0));
        chk("rst_ir3", 128'(ir3), 128'(1'b1));
        rstn = 1'b1;

        // AND vector: a=0xA5, b=0x0F unmasked
        a2 = 16'h993C; b2 = 16'h5A55; r2 = 8'h77; op2 = 1'b0; iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        chk("and_lat1", 128'(ov2), 128'(1'b0));
        step();
        chk("and_ov", 128'(ov2), 128'(1'b1));
        chk("and_q", 128'(q2), 128'(16'h7E7B));
        chk("and_fold", 128'(q2[15:8] ^ q2[7:0]), 128'(8'h05));
        step();
        chk("and_drain", 128'(ov2), 128'(1'b0));

        op2 = 1'b1; iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        step();
        chk("xor_q_r77", 128'(q2), 128'(16'hC369));
        r2 = 8'h00; iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        step();
        chk("xor_q_r00", 128'(q2), 128'(16'hC369));
        chk("xor_fold", 128'(q2[15:8] ^ q2[7:0]), 128'(8'hAA));
        op2 = 1'b0;
        step();

        // Back-to-back, out_ready held high
        for (int e = 0; e < 6; e++) begin
            if (e < 4) begin
                iv2 = 1'b1; a2 = ta[e]; b2 = tb[e]; r2 = tr[e];
            end else begin
                iv2 = 1'b0;
            end
            step();
            chk("b2b_ir", 128'(ir2), 128'(1'b1));
            if (e >= 1 && e <= 4) begin
                chk("b2b_ov", 128'(ov2), 128'(1'b1));
                chk("b2b_q", 128'(q2), 128'(ref2(ta[e-1], tb[e-1], tr[e-1], 1'b0)));
            end else if (e == 5) begin
                chk("b2b_end", 128'(ov2), 128'(1'b0));
            end
        end

        // Backpressure: three transactions, consumer stalled for five edges
        or2 = 1'b0;
        iv2 = 1'b1; a2 = ta[1]; b2 = tb[1]; r2 = tr[1];
        step();
        chk("bp_ir0", 128'(ir2), 128'(1'b1));
        chk("bp_ov0", 128'(ov2), 128'(1'b0));
        a2 = ta[2]; b2 = tb[2]; r2 = tr[2];
        step();
        chk("bp_ir1", 128'(ir2), 128'(1'b0));
        chk("bp_ov1", 128'(ov2), 128'(1'b1));
        chk("bp_q1", 128'(q2), 128'(ref2(ta[1], tb[1], tr[1], 1'b0)));
        a2 = ta[3]; b2 = tb[3]; r2 = tr[3];
        for (int n = 0; n < 3; n++) begin
            step();
            chk("bp_stall_ir", 128'(ir2), 128'(1'b0));
            chk("bp_stall_ov", 128'(ov2), 128'(1'b1));
            chk("bp_stall_q", 128'(q2), 128'(ref2(ta[1], tb[1], tr[1], 1'b0)));
        end
        or2 = 1'b1;
        step();
        chk("bp_rel_ov1", 128'(ov2), 128'(1'b1));
        chk("bp_rel_q1", 128'(q2), 128'(ref2(ta[2], tb[2], tr[2], 1'b0)));
        iv2 = 1'b0;
        step();
        chk("bp_rel_ov2", 128'(ov2), 128'(1'b1));
        chk("bp_rel_q2", 128'(q2), 128'(ref2(ta[3], tb[3], tr[3], 1'b0)));
        step();
        chk("bp_rel_end", 128'(ov2), 128'(1'b0));

        // Reset with both stages occupied
        iv2 = 1'b1; a2 = ta[0]; b2 = tb[0]; r2 = tr[0];
        step();
        a2 = ta[1]; b2 = tb[1]; r2 = tr[1];
        step();
        chk("mid_pre_ov", 128'(ov2), 128'(1'b1));
        rstn = 1'b0; iv2 = 1'b0;
        step();
        rstn = 1'b1;
        chk("mid_ov", 128'(ov2), 128'(1'b0));
        chk("mid_q", 128'(q2), 128'(16'h0));
        chk("mid_ir", 128'(ir2), 128'(1'b1));
        for (int n = 0; n < 3; n++) begin
            step();
            chk("mid_no_stale", 128'(ov2), 128'(1'b0));
        end

        // 3 shares, random operands at full throughput; check unmasked result
        or3 = 1'b1;
        for (int t = 0; t < 10000; t++) begin
            a3 = {$urandom(), $urandom(), $urandom()};
            b3 = {$urandom(), $urandom(), $urandom()};
            r3 = {$urandom(), $urandom(), $urandom()};
            op3 = 1'($urandom_range(0, 1));
            iv3 = 1'b1;
            ua = fold3(a3);
            ub = fold3(b3);
            eq.push_back(op3 ? (ua ^ ub) : (ua & ub));
            step();
            chk("r3_ir", 128'(ir3), 128'(1'b1));
            if (t >= 1) begin
                chk("r3_ov", 128'(ov3), 128'(1'b1));
                chk("r3_fold", 128'(fold3(q3)), 128'(eq.pop_front()));
            end
        end
        iv3 = 1'b0;
        step();
        chk("r3_last_ov", 128'(ov3), 128'(1'b1));
        chk("r3_last_fold", 128'(fold3(q3)), 128'(eq.pop_front()));
        step();
        chk("r3_drain", 128'(ov3), 128'(1'b0));

        // Same operands, only randomness changes: each share moves by its z deltas
        for (int n = 0; n < 4; n++) begin
            a3 = {$urandom(), $urandom(), $urandom()};
            b3 = {$urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom()};
            op3 = 1'b0; iv3 = 1'b1; r3 = rb;
            step();
            r3 = rb ^ {32'h4, 32'h2, 32'h1};
            step();
            qa = q3;
            iv3 = 1'b0;
            step();
            qb = q3;
            chk("mask_q0", 128'(qa[31:0] ^ qb[31:0]), 128'(32'h3));
            chk("mask_q1", 128'(qa[63:32] ^ qb[63:32]), 128'(32'h5));
            chk("mask_q2", 128'(qa[95:64] ^ qb[95:64]), 128'(32'h6));
            chk("mask_fold", 128'(fold3(qa) ^ fold3(qb)), 128'(32'h0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
